// File: rtl/receive_game_dificulty_if.sv
// Byte-stream and status signals between the UART receiver, the difficulty
// packet parser and game control.
interface receive_game_dificulty_if;
  logic       habilitar_recepcao;
  logic       dado_recebido;
  logic [7:0] dado_entrada;
  logic       game_dificulty;
  logic       dificulty_atualizada;
  logic       erro_pacote;
  logic       recepcao_ativa;

  modport slave (
    input  habilitar_recepcao,
    input  dado_recebido,
    input  dado_entrada,
    output game_dificulty,
    output dificulty_atualizada,
    output erro_pacote,
    output recepcao_ativa
  );

  modport master (
    output habilitar_recepcao,
    output dado_recebido,
    output dado_entrada,
    input  game_dificulty,
    input  dificulty_atualizada,
    input  erro_pacote,
    input  recepcao_ativa
  );
endinterface

// File: rtl/receive_game_dificulty.sv
// Parses a two-byte difficulty packet (EVENT_CODE, then 0/1 payload) from the
// UART byte stream and holds the resulting difficulty bit.
module receive_game_dificulty #(
  parameter logic [7:0] EVENT_CODE     = 8'hAB,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input logic                      clock,
  input logic                      reset,
  receive_game_dificulty_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] COUNT_SAT  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    ESPERA_PAYLOAD = 2'd1,
    FIM            = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] count, next_count;
  logic          dificulty_q, next_dificulty;
  logic          atualizada_q, next_atualizada;
  logic          erro_q, next_erro;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      dificulty_q  <= 1'b0;
      atualizada_q <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      state        <= next_state;
      count        <= next_count;
      dificulty_q  <= next_dificulty;
      atualizada_q <= next_atualizada;
      erro_q       <= next_erro;
    end
  end

  // A payload strobe wins over the timeout when both land in the same cycle.
  always_comb begin
    next_state      = state;
    next_count      = count;
    next_dificulty  = dificulty_q;
    next_atualizada = 1'b0;
    next_erro       = 1'b0;
    if (!bus.habilitar_recepcao) begin
      next_state = IDLE;
      next_count = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dado_recebido && (bus.dado_entrada == EVENT_CODE)) begin
            next_state = ESPERA_PAYLOAD;
            next_count = '0;
          end
        end
        ESPERA_PAYLOAD: begin
          if (bus.dado_recebido) begin
            next_state = FIM;
            if (bus.dado_entrada[7:1] == 7'd0) begin
              next_dificulty  = bus.dado_entrada[0];
              next_atualizada = 1'b1;
            end else begin
              next_erro = 1'b1;
            end
          end else begin
            next_count = (count == COUNT_SAT) ? count : count + CW'(1);
            if (count >= COUNT_LAST) begin
              next_state = FIM;
              next_erro  = 1'b1;
            end
          end
        end
        FIM:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  assign bus.game_dificulty       = dificulty_q;
  assign bus.dificulty_atualizada = atualizada_q;
  assign bus.erro_pacote          = erro_q;
  assign bus.recepcao_ativa       = (state == ESPERA_PAYLOAD);

endmodule

// File: tb/tb_receive_game_dificulty.sv
// Self-checking bench: directed vector table for the packet scenarios, then
// random traffic compared against an event-level reference model.
module tb_receive_game_dificulty;

  localparam int         TMO  = 10;
  localparam logic [7:0] CODE = 8'hAB;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  receive_game_dificulty_if bus ();

  receive_game_dificulty #(
    .EVENT_CODE    (CODE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  // exp packs {game_dificulty, dificulty_atualizada, erro_pacote, recepcao_ativa}
  typedef struct {
    string      name;
    logic       rst;
    logic       hab;
    logic       stb;
    logic [7:0] data;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input string n, input logic r, input logic h, input logic s,
                        input logic [7:0] d, input logic [3:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.hab = h; v.stb = s; v.data = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic s, input logic [7:0] d);
    reset                  = r;
    bus.habilitar_recepcao = h;
    bus.dado_recebido      = s;
    bus.dado_entrada       = d;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string n, input logic [3:0] exp);
    logic [3:0] act;
    act = {bus.game_dificulty, bus.dificulty_atualizada, bus.erro_pacote, bus.recepcao_ativa};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: dif/upd/err/ativa got %b required %b", n, act, exp);
    end
  endtask

  // Reference model: tracks whether a header is pending, how many idle cycles
  // have elapsed since it, and whether the cycle after a packet is running.
  bit waiting, closing, m_dif;
  int age;

  task automatic modelStep(input logic r, input logic h, input logic s, input logic [7:0] d,
                           output logic [3:0] exp);
    bit upd, err;
    upd = 0; err = 0;
    if (r) begin
      waiting = 0; closing = 0; m_dif = 0; age = 0;
    end else if (!h) begin
      waiting = 0; closing = 0;
    end else if (closing) begin
      closing = 0;
    end else if (waiting) begin
      if (s) begin
        if (d == 8'h00 || d == 8'h01) begin
          m_dif = d[0];
          upd   = 1;
        end else begin
          err = 1;
        end
        waiting = 0; closing = 1;
      end else begin
        age++;
        if (age >= TMO) begin
          err = 1; waiting = 0; closing = 1;
        end
      end
    end else if (s && d == CODE) begin
      waiting = 1; age = 0;
    end
    exp = {m_dif, upd, err, waiting};
  endtask

  initial begin
    logic [3:0] e;
    logic       r, h, s;
    logic [7:0] d;

    reset = 1'b1;
    bus.habilitar_recepcao = 1'b0;
    bus.dado_recebido = 1'b0;
    bus.dado_entrada = 8'h00;

    addVec("reset",        1, 0, 0, 8'h00, 4'b0000);
    addVec("p1_header",    0, 1, 1, CODE,  4'b0001);
    for (int i = 0; i < 3; i++) addVec("p1_wait", 0, 1, 0, 8'h00, 4'b0001);
    addVec("p1_payload",   0, 1, 1, 8'h01, 4'b1100);
    addVec("p1_after",     0, 1, 0, 8'h00, 4'b1000);
    addVec("p2_header",    0, 1, 1, CODE,  4'b1001);
    addVec("p2_bad",       0, 1, 1, 8'h05, 4'b1010);
    addVec("p2_after",     0, 1, 0, 8'h00, 4'b1000);
    addVec("p3_junk12",    0, 1, 1, 8'h12, 4'b1000);
    addVec("p3_stray01",   0, 1, 1, 8'h01, 4'b1000);
    addVec("p3_header",    0, 1, 1, CODE,  4'b1001);
    addVec("p3_payload00", 0, 1, 1, 8'h00, 4'b0100);
    addVec("p3_after",     0, 1, 0, 8'h00, 4'b0000);
    addVec("tmo_header",   0, 1, 1, CODE,  4'b0001);
    for (int i = 1; i < TMO; i++) addVec("tmo_wait", 0, 1, 0, 8'h00, 4'b0001);
    addVec("tmo_error",    0, 1, 0, 8'h00, 4'b0010);
    addVec("tmo_fim_byte", 0, 1, 1, 8'h01, 4'b0000);
    addVec("tmo_after",    0, 1, 0, 8'h00, 4'b0000);
    addVec("edge_header",  0, 1, 1, CODE,  4'b0001);
    for (int i = 1; i < TMO; i++) addVec("edge_wait", 0, 1, 0, 8'h00, 4'b0001);
    addVec("edge_payload", 0, 1, 1, 8'h01, 4'b1100);
    addVec("edge_after",   0, 1, 0, 8'h00, 4'b1000);
    addVec("hab_header",   0, 1, 1, CODE,  4'b1001);
    addVec("hab_low",      0, 0, 0, 8'h00, 4'b1000);
    addVec("hab_byte00",   0, 1, 1, 8'h00, 4'b1000);
    addVec("hab_after",    0, 1, 0, 8'h00, 4'b1000);
    addVec("rst_header",   0, 1, 1, CODE,  4'b1001);
    addVec("rst_mid",      1, 1, 0, 8'h00, 4'b0000);
    addVec("rst_byte01",   0, 1, 1, 8'h01, 4'b0000);
    addVec("rst_after",    0, 1, 0, 8'h00, 4'b0000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].hab, vecs[i].stb, vecs[i].data);
      checkOutput(vecs[i].name, vecs[i].exp);
    end

    applyStimulus(1, 1, 0, 8'h00);
    modelStep(1, 1, 0, 8'h00, e);
    checkOutput("rand_reset", e);

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      h = ($urandom_range(0, 99) >= 4);
      s = ($urandom_range(0, 99) < 20);
      case ($urandom_range(0, 3))
        0:       d = CODE;
        1:       d = 8'h00;
        2:       d = 8'h01;
        default: d = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(r, h, s, d);
      modelStep(r, h, s, d, e);
      checkOutput("random", e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/receive_game_dificulty.md
# receive_game_dificulty

Receive-side counterpart of the game-difficulty event sender. Sits between the UART receiver and game control. It parses the incoming byte stream for a two-byte difficulty packet (event code, then payload), validates the payload, and holds the resulting difficulty bit. It also flags malformed or stalled packets.

## Interface

Parameters:
- EVENT_CODE, 8'hAB, packet header byte that identifies a difficulty event.
- TIMEOUT_CYCLES, 50_000_000, maximum clock cycles allowed between header and payload byte; must be ≥ 2.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- habilitar_recepcao  input  1  level; when low, the parser is held in IDLE and incoming bytes are ignored.
- dado_recebido  input  1  one-cycle strobe from the UART receiver; `dado_entrada` is valid in this cycle.
- dado_entrada  input  8  received byte.
- game_dificulty  output  1  registered current difficulty (0 = easy, 1 = hard).
- dificulty_atualizada  output  1  one-cycle pulse when a valid packet updates `game_dificulty`.
- erro_pacote  output  1  one-cycle pulse on an invalid payload or a timeout.
- recepcao_ativa  output  1  high while the header has been accepted and the payload is awaited.

## Operation

- The FSM has three states: IDLE, ESPERA_PAYLOAD and FIM.
- IDLE:
  - On `dado_recebido` with `dado_entrada == EVENT_CODE`, go to ESPERA_PAYLOAD and clear the timeout counter.
  - Any other byte is silently discarded. No error is raised.
- ESPERA_PAYLOAD:
  - The timeout counter increments every cycle without `dado_recebido`.
  - On `dado_recebido` with `dado_entrada` equal to 8'h00 or 8'h01:
    - Register `dado_entrada[0]` into `game_dificulty`.
    - Raise the update flag and go to FIM.
  - On `dado_recebido` with any other value, including a repeated EVENT_CODE:
    - Raise the error flag, leave `game_dificulty` unchanged and go to FIM.
  - When the counter reaches TIMEOUT_CYCLES with no byte, raise the error flag and go to FIM.
- FIM lasts one cycle, then the FSM returns to IDLE unconditionally. A byte strobed during FIM is ignored.
- Output registers:
  - `dificulty_atualizada` and `erro_pacote` are registered outputs, asserted exactly during the FIM cycle.
  - They are mutually exclusive.
- `habilitar_recepcao` low, in any state: next state is IDLE, the counter clears and no pulse is generated. `game_dificulty` holds its value.
- Counter width is $clog2(TIMEOUT_CYCLES+1) bits. The counter saturates rather than wraps.

## Timing

- Reset values:
  - `game_dificulty` = 0, `dificulty_atualizada` = 0, `erro_pacote` = 0, `recepcao_ativa` = 0.
  - FSM in IDLE, counter = 0.
- Latency: the payload strobe in cycle N updates `game_dificulty` and raises `dificulty_atualizada` at the edge ending cycle N, so both are visible in cycle N+1. `recepcao_ativa` drops in the same cycle N+1.
- `recepcao_ativa` rises the cycle after the header strobe. It is a registered decode of ESPERA_PAYLOAD.
- Timeout boundary:
  - With the header in cycle H and no further strobe, `erro_pacote` is high in cycle H+1+TIMEOUT_CYCLES.
  - A payload strobe in the same cycle the counter reaches its limit is accepted as data, not treated as a timeout.
- Back-to-back packets: a new header is accepted no earlier than the cycle after FIM, since FIM ignores strobes. The UART's minimum byte spacing makes this a non-issue in practice.
- Reset asserted mid-packet: next cycle is IDLE with all outputs at their reset values. No pulse is emitted.

## Test plan

- Reset, then header 8'hAB, then 8'h01 four cycles later -> `recepcao_ativa` high for 4 cycles; `game_dificulty` = 1 and a single-cycle `dificulty_atualizada` the cycle after the payload strobe.
- Set difficulty to 1, then send 8'hAB followed by 8'h05 -> one `erro_pacote` pulse; `game_dificulty` stays 1; `dificulty_atualizada` never asserts.
- Send bytes 8'h12 and 8'h01, then 8'hAB and 8'h00 -> the first two bytes are ignored (`recepcao_ativa` stays 0); after the valid packet `game_dificulty` = 0 and `dificulty_atualizada` pulses once.
- With TIMEOUT_CYCLES = 10, send 8'hAB and no further bytes -> `erro_pacote` pulses exactly 11 cycles after the header strobe, then `recepcao_ativa` = 0. A follow-up 8'h01 is ignored.
- Send 8'hAB, then drop `habilitar_recepcao` for 1 cycle, then send 8'h01 -> the FSM is back in IDLE, the 8'h01 is ignored and `game_dificulty` is unchanged.
- Send 8'hAB, then assert `reset` before the payload -> all outputs 0 on the next cycle; a payload 8'h01 arriving after reset releases produces no update.
